// File: rtl/set_counter_gen.sv
// Set-membership counter: scans the GRID_N x GRID_N lattice one point per cycle
// and counts the points that satisfy a set expression over circles A, B and C.
module set_counter_gen #(
  parameter int unsigned GRID_N  = 8,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [6*COORD_W-1:0]   central,
  input  logic [3*COORD_W-1:0]   radius,
  input  logic [2:0]             mode,
  output logic                   busy,
  output logic                   valid,
  output logic [CNT_W-1:0]       candidate
);

  localparam int unsigned SQ_W  = 2 * COORD_W;
  localparam int unsigned SUM_W = 2 * COORD_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [COORD_W-1:0]     x_q, y_q;
  logic [6*COORD_W-1:0]   cen_q;
  logic [3*COORD_W-1:0]   rad_q;
  logic [2:0]             mode_q;
  logic                   hit_q, drain_q;
  logic                   busy_q, valid_q;
  logic [CNT_W-1:0]       candidate_q;

  logic                   a_in, b_in, c_in, hit_d;

  // Full-width distance test: squares at 2*COORD_W bits, sum one bit wider.
  function automatic logic in_circle(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy,
                                     input logic [COORD_W-1:0] r);
    logic [COORD_W-1:0] dx, dy;
    logic [SQ_W-1:0]    dx2, dy2, r2;
    logic [SUM_W-1:0]   sum;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dx2 = SQ_W'(dx) * SQ_W'(dx);
    dy2 = SQ_W'(dy) * SQ_W'(dy);
    r2  = SQ_W'(r) * SQ_W'(r);
    sum = SUM_W'(dx2) + SUM_W'(dy2);
    return (sum <= SUM_W'(r2));
  endfunction

  always_comb begin
    a_in  = in_circle(x_q, y_q, cen_q[6*COORD_W-1 -: COORD_W], cen_q[5*COORD_W-1 -: COORD_W],
                      rad_q[3*COORD_W-1 -: COORD_W]);
    b_in  = in_circle(x_q, y_q, cen_q[4*COORD_W-1 -: COORD_W], cen_q[3*COORD_W-1 -: COORD_W],
                      rad_q[2*COORD_W-1 -: COORD_W]);
    c_in  = in_circle(x_q, y_q, cen_q[2*COORD_W-1 -: COORD_W], cen_q[COORD_W-1 -: COORD_W],
                      rad_q[COORD_W-1 -: COORD_W]);
    hit_d = 1'b0;
    case (mode_q)
      3'b000:  hit_d = a_in;
      3'b001:  hit_d = a_in & b_in;
      3'b010:  hit_d = a_in ^ b_in;
      3'b011:  hit_d = (a_in & b_in & ~c_in) | (a_in & ~b_in & c_in) | (~a_in & b_in & c_in);
      3'b100:  hit_d = a_in | b_in;
      3'b101:  hit_d = a_in | b_in | c_in;
      3'b110:  hit_d = a_in & b_in & c_in;
      default: hit_d = 1'b0;
    endcase
  end

  // Membership is registered, so the count trails the scan by one cycle (drain).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cen_q       <= '0;
      rad_q       <= '0;
      mode_q      <= '0;
      hit_q       <= 1'b0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      candidate_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (en) begin
            cen_q       <= central;
            rad_q       <= radius;
            mode_q      <= mode;
            candidate_q <= '0;
            x_q         <= COORD_W'(1);
            y_q         <= COORD_W'(1);
            hit_q       <= 1'b0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          candidate_q <= candidate_q + CNT_W'(hit_q);
          if (drain_q) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            hit_q <= hit_d;
            if (x_q == COORD_W'(GRID_N)) begin
              if (y_q == COORD_W'(GRID_N)) begin
                drain_q <= 1'b1;
              end else begin
                x_q <= COORD_W'(1);
                y_q <= y_q + COORD_W'(1);
              end
            end else begin
              x_q <= x_q + COORD_W'(1);
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign candidate = candidate_q;

endmodule

// File: tb/tb_set_counter_gen.sv
// Bench for set_counter_gen: directed and random commands against a lattice-count model.
module tb_set_counter_gen;

  localparam int unsigned N = 8;
  localparam int unsigned W = 4;
  localparam int unsigned C = 8;

  logic         clk, rst, en;
  logic [6*W-1:0] central;
  logic [3*W-1:0] radius;
  logic [2:0]   mode;
  logic         busy, valid;
  logic [C-1:0] candidate;

  int checks   = 0;
  int failures = 0;
  longint t_valid = 0;

  set_counter_gen #(.GRID_N(N), .COORD_W(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_c(int x, int y, int kx, int ky, int r);
    return (x - kx) * (x - kx) + (y - ky) * (y - ky) <= r * r;
  endfunction

  // Reference: count grid points satisfying the selected set expression.
  function automatic int model(logic [6*W-1:0] cen, logic [3*W-1:0] rad, logic [2:0] md);
    int k[6];
    int r[3];
    int cnt = 0;
    for (int i = 0; i < 6; i++) k[i] = int'(cen[(5-i)*W +: W]);
    for (int i = 0; i < 3; i++) r[i] = int'(rad[(2-i)*W +: W]);
    for (int y = 1; y <= int'(N); y++)
      for (int x = 1; x <= int'(N); x++) begin
        bit a, b, c, t;
        a = in_c(x, y, k[0], k[1], r[0]);
        b = in_c(x, y, k[2], k[3], r[1]);
        c = in_c(x, y, k[4], k[5], r[2]);
        case (md)
          3'd0: t = a;
          3'd1: t = a && b;
          3'd2: t = a != b;
          3'd3: t = (int'(a) + int'(b) + int'(c)) == 2;
          3'd4: t = a || b;
          3'd5: t = a || b || c;
          3'd6: t = a && b && c;
          default: t = 1'b0;
        endcase
        if (t) cnt++;
      end
    return cnt;
  endfunction

  // Issue one command, optionally pulse en again mid-scan, and check the whole transaction.
  task automatic run_cmd(input string tag, input logic [6*W-1:0] cen, input logic [3*W-1:0] rad,
                         input logic [2:0] md, input int inject_at, input int exp_direct);
    int n;
    int exp;
    exp = model(cen, rad, md);
    if (exp_direct >= 0) check({tag, " model"}, exp, exp_direct);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1; n++;
    end
    central = cen; radius = rad; mode = md; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    check({tag, " busy_rise"}, int'(busy), 1);
    n = 0;
    while (!valid && n < 300) begin
      if (n == inject_at) begin
        central = 24'($urandom); radius = 12'($urandom); mode = 3'($urandom); en = 1'b1;
      end
      @(posedge clk); #1;
      en = 1'b0;
      n++;
    end
    t_valid = $time;
    check({tag, " latency"}, n, int'(N * N + 1));
    check({tag, " candidate"}, int'(candidate), exp);
    check({tag, " busy_in_done"}, int'(busy), 1);
    @(posedge clk); #1;
    check({tag, " valid_drop"}, int'(valid), 0);
    check({tag, " busy_fall"}, int'(busy), 0);
    check({tag, " hold"}, int'(candidate), exp);
  endtask

  function automatic logic [6*W-1:0] cpack(int ax, int ay, int bx, int by, int cx, int cy);
    return {W'(ax), W'(ay), W'(bx), W'(by), W'(cx), W'(cy)};
  endfunction

  function automatic logic [3*W-1:0] rpack(int ra, int rb, int rc);
    return {W'(ra), W'(rb), W'(rc)};
  endfunction

  initial begin
    longint t_first;
    int n;
    rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0;
    #23;
    check("reset busy", int'(busy), 0);
    check("reset valid", int'(valid), 0);
    check("reset candidate", int'(candidate), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_cmd("circle", cpack(4, 4, 0, 0, 0, 0), rpack(2, 0, 0), 3'b000, -1, 13);
    run_cmd("and", cpack(4, 4, 4, 4, 0, 0), rpack(2, 1, 0), 3'b001, -1, 5);
    run_cmd("xor", cpack(4, 4, 4, 4, 0, 0), rpack(2, 1, 0), 3'b010, -1, 8);
    run_cmd("or", cpack(4, 4, 4, 4, 0, 0), rpack(2, 1, 0), 3'b100, -1, 13);
    run_cmd("clip", cpack(1, 1, 0, 0, 0, 0), rpack(2, 0, 0), 3'b000, -1, 6);
    run_cmd("r0_or", cpack(2, 2, 7, 7, 0, 0), rpack(0, 0, 0), 3'b100, -1, 2);
    run_cmd("r0_out", cpack(0, 0, 0, 0, 0, 0), rpack(0, 0, 0), 3'b000, -1, 0);
    run_cmd("two", cpack(4, 4, 4, 4, 8, 8), rpack(1, 1, 0), 3'b011, -1, 5);
    run_cmd("triple", cpack(4, 4, 4, 4, 8, 8), rpack(1, 1, 0), 3'b110, -1, 0);
    run_cmd("union3", cpack(4, 4, 4, 4, 8, 8), rpack(1, 1, 0), 3'b101, -1, 6);
    run_cmd("reserved", cpack(4, 4, 4, 4, 4, 4), rpack(15, 15, 15), 3'b111, -1, 0);
    run_cmd("full", cpack(4, 4, 0, 0, 0, 0), rpack(15, 0, 0), 3'b000, -1, 64);

    // en mid-scan with different operands must not disturb the running command.
    run_cmd("ignore", cpack(4, 4, 0, 0, 0, 0), rpack(2, 0, 0), 3'b000, 10, 13);

    // en driven in the cycle busy falls: next valid follows N*N+3 cycles later.
    t_first = t_valid;
    run_cmd("b2b", cpack(5, 3, 2, 6, 7, 7), rpack(3, 2, 4), 3'b101, -1, -1);
    check("b2b spacing", int'((t_valid - t_first) / 10), int'(N * N + 3));

    // Reset mid-scan aborts without a result pulse.
    central = cpack(4, 4, 0, 0, 0, 0); radius = rpack(3, 0, 0); mode = 3'b000; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst valid", int'(valid), 0);
    check("rst candidate", int'(candidate), 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (valid) n++;
    end
    check("rst no_valid", n, 0);
    run_cmd("after_rst", cpack(3, 6, 0, 0, 0, 0), rpack(2, 0, 0), 3'b000, -1, -1);

    for (int i = 0; i < 10; i++) begin
      run_cmd($sformatf("rand%0d", i), 24'($urandom), 12'($urandom), 3'($urandom), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
